game_move_engine: RTL and testbench
===================================

// Module: game_move_engine
// PURPOSE
//  Sokoban move engine: accepts one direction command, reads the current game state (q of the
//  134-bit game state register), resolves walk/push/blocked, drives next state + one-cycle enable
//  into the state register's d/en inputs. Sits directly upstream of the game state register.
//  State layout: [133:128] player pos {row[2:0],col[2:0]}; cell i=row*8+col at [2i+1:2i].
//  Cell codes: 00 floor, 01 wall, 10 box, 11 reserved (treated as wall).
// PARAMETERS
//  N       134  state width; fixed = 2*64+6, 8x8 grid
//  STEP_W  16   width of successful-move counter
// PORTS
//  clk        in   1       system clock, rising edge
//  r_n        in   1       asynchronous active-low reset
//  cmd_valid  in   1       direction command valid
//  cmd_dir    in   2       00 up(row-1), 01 down(row+1), 10 left(col-1), 11 right(col+1)
//  cmd_ready  out  1       engine can accept command (high only in IDLE)
//  cur_state  in   N       current game state (state register q)
//  st_d       out  N       next game state (to state register d)
//  st_en      out  1       one-cycle load enable (to state register en)
//  move_done  out  1       one-cycle pulse: command resolved
//  move_ok    out  1       valid with move_done: 1 = state changed
//  pushed     out  1       valid with move_done: 1 = a box was pushed
//  step_clr   in   1       synchronous clear of step counter (level load)
//  steps      out  STEP_W  count of successful moves, saturating
//  goal_mask  in   64      goal cells, bit i = cell i (used only with WIN_DETECT_EN)
//  win        out  1       all goal cells hold boxes
// BEHAVIOUR
//  - Reset (r_n=0, any state, any cycle): FSM->IDLE; st_en, move_done, move_ok, pushed, win, steps,
//    st_d all 0; cmd_ready=1 after reset release. Command in flight is dropped, no st_en.
//  - FSM IDLE -> CHECK on cmd_valid&cmd_ready; cmd_dir and cur_state latched at accept.
//    CHECK: compute T=pos+1 step, B=pos+2 steps; bounds from row/col (no wrap: col 7 right,
//    col 0 left, row 0 up, row 7 down are off-grid). Register result and next state.
//    COMMIT: st_en=1 iff move_ok; move_done=1; -> IDLE. Accept-to-st_en latency = 2 cycles.
//  - Resolution: T off-grid or wall/reserved -> blocked. T floor -> walk (pos=T).
//    T box: B off-grid, wall, reserved or box -> blocked; B floor -> push (cell T=00, cell B=10,
//    pos=T, pushed=1). Blocked: move_ok=0, st_en=0, st_d holds latched cur_state.
//  - cmd_valid while not IDLE ignored (cmd_ready=0); no queueing.
//  - st_d holds last computed value outside COMMIT; only st_en qualifies it.
//  - steps: +1 in COMMIT when move_ok; saturates at 2^STEP_W-1. step_clr same cycle as increment:
//    clear wins (steps=0).
//  - cur_state is only sampled at accept; changes during CHECK/COMMIT have no effect.
// CONFIGURATION
//  - WIN_DETECT_EN defined: win registered, updated in cycle after each COMMIT with move_ok and on
//    step_clr: win = goal_mask!=0 and every goal_mask cell == 10 in state just committed; step_clr
//    clears win to 0.
//  - WIN_DETECT_EN undefined: win tied 0, goal_mask unused; ports kept for integration.
// TESTING
//  - Walk: pos=9 (r1c1), cell10=00, cmd_dir=11 -> 2 cycles after accept st_en=1,
//    st_d[133:128]=10, move_ok=1, pushed=0, steps=1.
//  - Push: pos=9, cell10=10, cell11=00, dir=11 -> cell10=00, cell11=10, pos=10, pushed=1.
//  - Blocked push: pos=9, cell10=10, cell11=01, dir=11 -> move_done=1, move_ok=0, st_en never 1,
//    steps unchanged; repeat with cell11=10 -> same.
//  - Edges: pos=7 dir=11, pos=0 dir=00, pos=56 dir=01, pos=8 dir=10 -> all blocked, no wrap;
//    pos=6 with box at 7 dir=11 -> blocked.
//  - Control: cmd_valid held through CHECK/COMMIT -> exactly one accept; r_n low during COMMIT ->
//    st_en=0 immediately, steps=0; steps at 0xFFFF + walk -> stays 0xFFFF; step_clr+walk -> 0.
//  - WIN_DETECT_EN: goal_mask=1<<11, push box into cell11 -> win=1 one cycle after COMMIT;
//    step_clr -> win=0; undefined -> win stays 0.

Source files
------------

// File: rtl/game_move_engine.sv
// -----------------------------------------------------------------------------
// game_move_engine
//
// Sokoban move engine. It accepts one direction command, takes a snapshot of the
// current game state, and resolves the move as a walk, a push or a blocked move.
// It then presents the next state to the game state register with a one-cycle
// load enable.
//
// State layout (N = 134):
//   [133:128]  player position {row[2:0], col[2:0]}
//   [2i+1:2i]  cell i = row*8 + col
// Cell codes: 00 floor, 01 wall, 10 box, 11 reserved (behaves as a wall).
//
// Ports:
//   clk        rising-edge clock
//   r_n        asynchronous active-low reset
//   cmd_valid  direction command valid
//   cmd_dir    00 up, 01 down, 10 left, 11 right
//   cmd_ready  high only while idle
//   cur_state  game state register q (sampled only when a command is accepted)
//   st_d       next game state (game state register d)
//   st_en      one-cycle load enable (game state register en)
//   move_done  one-cycle pulse when a command is resolved
//   move_ok    qualified by move_done: state changed
//   pushed     qualified by move_done: a box was pushed
//   step_clr   synchronous clear of the step counter (and of win)
//   steps      saturating count of successful moves
//   goal_mask  goal cells, bit i = cell i
//   win        every goal cell holds a box
//
// Optional feature: define WIN_DETECT_EN to build the registered win detector.
// Without it, win is tied low and goal_mask is ignored. Both ports are kept so
// that integration does not depend on the build.
// -----------------------------------------------------------------------------
module game_move_engine #(
    parameter int N      = 134,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              r_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_dir,
    output logic              cmd_ready,
    input  logic [N-1:0]      cur_state,
    output logic [N-1:0]      st_d,
    output logic              st_en,
    output logic              move_done,
    output logic              move_ok,
    output logic              pushed,
    input  logic              step_clr,
    output logic [STEP_W-1:0] steps,
    input  logic [63:0]       goal_mask,
    output logic              win
);

    localparam logic [1:0] C_FLOOR = 2'b00;
    localparam logic [1:0] C_BOX   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t state_q, state_n;

    logic [1:0]   dir_p0;
    logic [N-1:0] snap_p0;
    logic         ok_p1;
    logic         push_p1;

    logic [N-1:0] res_state;
    logic         res_ok;
    logic         res_push;

    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
        if (&v) return v;
        return v + {{(STEP_W-1){1'b0}}, 1'b1};
    endfunction

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) state_q <= S_IDLE;
        else      state_q <= state_n;
    end

    // ---- FSM next state and control outputs ----
    always_comb begin
        state_n   = state_q;
        cmd_ready = 1'b0;
        move_done = 1'b0;
        st_en     = 1'b0;
        move_ok   = 1'b0;
        pushed    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_n = S_CHECK;
            end
            S_CHECK: state_n = S_COMMIT;
            S_COMMIT: begin
                move_done = 1'b1;
                st_en     = ok_p1;
                move_ok   = ok_p1;
                pushed    = push_p1;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // ---- stage p0 -> p1: resolve the latched command against the snapshot ----
    always_comb begin
        logic [5:0] pos, t_idx, b_idx;
        logic [2:0] row, col;
        logic       t_in, b_in;
        logic [1:0] t_cell, b_cell;

        pos   = snap_p0[N-1 -: 6];
        row   = pos[5:3];
        col   = pos[2:0];
        t_in  = 1'b0;
        b_in  = 1'b0;
        t_idx = pos;
        b_idx = pos;
        // Bounds come from row/col so that index arithmetic never wraps onto
        // the next row or around the grid.
        case (dir_p0)
            2'b00: begin t_in = (row != 3'd0); b_in = (row >= 3'd2); t_idx = pos - 6'd8; b_idx = pos - 6'd16; end
            2'b01: begin t_in = (row != 3'd7); b_in = (row <= 3'd5); t_idx = pos + 6'd8; b_idx = pos + 6'd16; end
            2'b10: begin t_in = (col != 3'd0); b_in = (col >= 3'd2); t_idx = pos - 6'd1; b_idx = pos - 6'd2;  end
            default: begin t_in = (col != 3'd7); b_in = (col <= 3'd5); t_idx = pos + 6'd1; b_idx = pos + 6'd2; end
        endcase
        t_cell = snap_p0[{1'b0, t_idx, 1'b0} +: 2];
        b_cell = snap_p0[{1'b0, b_idx, 1'b0} +: 2];

        // Blocked moves hand back the snapshot unchanged.
        res_state = snap_p0;
        res_ok    = 1'b0;
        res_push  = 1'b0;
        if (t_in) begin
            if (t_cell == C_FLOOR) begin
                res_ok               = 1'b1;
                res_state[N-1 -: 6]  = t_idx;
            end else if (t_cell == C_BOX && b_in && b_cell == C_FLOOR) begin
                res_ok                                = 1'b1;
                res_push                              = 1'b1;
                res_state[N-1 -: 6]                   = t_idx;
                res_state[{1'b0, t_idx, 1'b0} +: 2]   = C_FLOOR;
                res_state[{1'b0, b_idx, 1'b0} +: 2]   = C_BOX;
            end
        end
    end

    // ---- stage p0 capture at accept, stage p1 result capture in CHECK ----
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            dir_p0  <= 2'b00;
            snap_p0 <= '0;
            st_d    <= '0;
            ok_p1   <= 1'b0;
            push_p1 <= 1'b0;
        end else begin
            if (state_q == S_IDLE && cmd_valid) begin
                dir_p0  <= cmd_dir;
                snap_p0 <= cur_state;
            end
            if (state_q == S_CHECK) begin
                st_d    <= res_state;
                ok_p1   <= res_ok;
                push_p1 <= res_push;
            end
        end
    end

    // ---- step counter: clear has priority over the commit increment ----
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n)                           steps <= '0;
        else if (step_clr)                  steps <= '0;
        else if (state_q == S_COMMIT && ok_p1) steps <= sat_inc(steps);
    end

`ifdef WIN_DETECT_EN
    function automatic logic win_eval(input logic [63:0] mask, input logic [N-1:0] s);
        logic all_box;
        all_box = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (mask[i] && s[2*i +: 2] != C_BOX) all_box = 1'b0;
        end
        return (mask != 64'd0) && all_box;
    endfunction

    // Evaluated on st_d while it holds the state being committed, so win
    // reflects that state from the cycle after COMMIT.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n)                              win <= 1'b0;
        else if (step_clr)                     win <= 1'b0;
        else if (state_q == S_COMMIT && ok_p1) win <= win_eval(goal_mask, st_d);
    end
`else
    logic unused_goal;
    assign unused_goal = ^goal_mask;
    assign win         = 1'b0;
`endif

endmodule

// File: tb/tb_game_move_engine.sv
// -----------------------------------------------------------------------------
// tb_game_move_engine
//
// Directed scoreboard bench for game_move_engine. The driver pushes the
// hand-computed expected result of each command into a queue. The monitor pops
// the queue on every move_done and compares. A narrow step counter keeps the
// saturation case short.
// -----------------------------------------------------------------------------
module tb_game_move_engine;

    localparam int N  = 134;
    localparam int SW = 4;
    localparam logic [SW-1:0] SMAX = '1;
`ifdef WIN_DETECT_EN
    localparam bit WIN_ON = 1'b1;
`else
    localparam bit WIN_ON = 1'b0;
`endif

    localparam logic [1:0] FLR = 2'b00, WAL = 2'b01, BOX = 2'b10, RSV = 2'b11;
    localparam logic [1:0] UP = 2'b00, DN = 2'b01, LF = 2'b10, RT = 2'b11;

    logic          clk;
    logic          r_n;
    logic          cmd_valid;
    logic [1:0]    cmd_dir;
    logic          cmd_ready;
    logic [N-1:0]  cur_state;
    logic [N-1:0]  st_d;
    logic          st_en;
    logic          move_done;
    logic          move_ok;
    logic          pushed;
    logic          step_clr;
    logic [SW-1:0] steps;
    logic [63:0]   goal_mask;
    logic          win;

    game_move_engine #(.N(N), .STEP_W(SW)) dut (
        .clk(clk), .r_n(r_n), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(cmd_ready), .cur_state(cur_state), .st_d(st_d), .st_en(st_en),
        .move_done(move_done), .move_ok(move_ok), .pushed(pushed),
        .step_clr(step_clr), .steps(steps), .goal_mask(goal_mask), .win(win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  d;
        bit            ok;
        bit            psh;
        logic [SW-1:0] stp;
        bit            w;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [SW-1:0] exp_steps = '0;
    bit            exp_win = 1'b0;

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic logic [N-1:0] mk(input logic [5:0] pos);
        logic [N-1:0] s;
        s = '0;
        s[N-1 -: 6] = pos;
        return s;
    endfunction

    function automatic logic [N-1:0] setc(input logic [N-1:0] s, input int idx, input logic [1:0] c);
        logic [N-1:0] r;
        r = s;
        r[2*idx +: 2] = c;
        return r;
    endfunction

    function automatic logic [N-1:0] setp(input logic [N-1:0] s, input logic [5:0] pos);
        logic [N-1:0] r;
        r = s;
        r[N-1 -: 6] = pos;
        return r;
    endfunction

    // Monitor: checks each resolved command, then the counter/win a cycle later.
    initial begin
        bit   pend;
        exp_t cur;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("steps", steps, cur.stp);
                chk("win", win, cur.w);
                pend = 1'b0;
            end
            if (move_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_move_done: got 1, expected 0");
                end else begin
                    cur = sb.pop_front();
                    chk("st_d", st_d, cur.d);
                    chk("move_ok", move_ok, cur.ok);
                    chk("pushed", pushed, cur.psh);
                    chk("st_en", st_en, cur.ok);
                    pend = 1'b1;
                end
            end
        end
    end

    // Issue one command. ed/ok/psh/w are the hand-computed expected results.
    task automatic run_cmd(input string nm, input logic [N-1:0] s, input logic [1:0] dir,
                           input logic [N-1:0] ed, input bit ok, input bit psh, input bit w,
                           input bit clr, input bit hold);
        exp_t e;
        @(negedge clk);
        chk({nm, "_ready_idle"}, cmd_ready, 1);
        cur_state = s;
        cmd_dir   = dir;
        cmd_valid = 1'b1;
        if (clr)                          exp_steps = '0;
        else if (ok && exp_steps != SMAX) exp_steps = exp_steps + 1'b1;
        if (clr)     exp_win = 1'b0;
        else if (ok) exp_win = w & WIN_ON;
        e.d = ed; e.ok = ok; e.psh = psh; e.stp = exp_steps; e.w = exp_win;
        sb.push_back(e);
        @(negedge clk);                       // CHECK
        if (!hold) cmd_valid = 1'b0;
        cur_state = ~s;                       // must not be re-sampled
        chk({nm, "_ready_check"}, cmd_ready, 0);
        chk({nm, "_done_early"}, move_done, 0);
        @(negedge clk);                       // COMMIT
        chk({nm, "_latency"}, move_done, 1);
        chk({nm, "_ready_commit"}, cmd_ready, 0);
        if (clr) step_clr = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        step_clr  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] s;
        r_n       = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 2'b00;
        cur_state = '0;
        step_clr  = 1'b0;
        goal_mask = 64'd1 << 11;
        #1 r_n = 1'b0;
        repeat (3) @(negedge clk);
        r_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_st_en", st_en, 0);
        chk("rst_done", move_done, 0);
        chk("rst_ok", move_ok, 0);
        chk("rst_pushed", pushed, 0);
        chk("rst_steps", steps, 0);
        chk("rst_st_d", st_d, 0);
        chk("rst_win", win, 0);

        // Walks in all four directions from r1c1
        s = mk(9);
        run_cmd("walk_rt", s, RT, setp(s, 10), 1, 0, 0, 0, 0);
        run_cmd("walk_dn", s, DN, setp(s, 17), 1, 0, 0, 0, 0);
        run_cmd("walk_lf", s, LF, setp(s, 8),  1, 0, 0, 0, 0);
        run_cmd("walk_up", s, UP, setp(s, 1),  1, 0, 0, 0, 0);

        // Pushes
        s = setc(mk(9), 17, BOX);
        run_cmd("push_dn", s, DN, setc(setc(setp(s, 17), 17, FLR), 25, BOX), 1, 1, 0, 0, 0);
        s = setc(mk(10), 9, BOX);
        run_cmd("push_lf", s, LF, setc(setc(setp(s, 9), 9, FLR), 8, BOX), 1, 1, 0, 0, 0);

        // Blocked cases: state must come back unchanged
        s = setc(setc(mk(9), 10, BOX), 11, WAL);
        run_cmd("blk_push_wall", s, RT, s, 0, 0, 0, 0, 0);
        s = setc(setc(mk(9), 10, BOX), 11, BOX);
        run_cmd("blk_push_box", s, RT, s, 0, 0, 0, 0, 0);
        s = setc(setc(mk(9), 10, BOX), 11, RSV);
        run_cmd("blk_push_rsv", s, RT, s, 0, 0, 0, 0, 0);
        s = setc(mk(9), 1, WAL);
        run_cmd("blk_wall", s, UP, s, 0, 0, 0, 0, 0);
        s = setc(mk(9), 10, RSV);
        run_cmd("blk_rsv", s, RT, s, 0, 0, 0, 0, 0);

        // Grid edges: no wrap
        s = mk(7);  run_cmd("edge_c7_rt", s, RT, s, 0, 0, 0, 0, 0);
        s = mk(0);  run_cmd("edge_r0_up", s, UP, s, 0, 0, 0, 0, 0);
        s = mk(56); run_cmd("edge_r7_dn", s, DN, s, 0, 0, 0, 0, 0);
        s = mk(8);  run_cmd("edge_c0_lf", s, LF, s, 0, 0, 0, 0, 0);
        s = setc(mk(6), 7, BOX); run_cmd("edge_box_c7", s, RT, s, 0, 0, 0, 0, 0);
        s = setc(mk(9), 8, BOX); run_cmd("edge_box_c0", s, LF, s, 0, 0, 0, 0, 0);

        // cmd_valid held through CHECK and COMMIT: one accept only
        s = mk(9);
        run_cmd("hold_valid", s, RT, setp(s, 10), 1, 0, 0, 0, 1);

        // Push a box onto the goal cell 11
        s = setc(mk(9), 10, BOX);
        run_cmd("push_goal", s, RT, setc(setc(setp(s, 10), 10, FLR), 11, BOX), 1, 1, 1, 0, 0);
        @(negedge clk);
        step_clr = 1'b1;
        @(negedge clk);
        step_clr  = 1'b0;
        exp_steps = '0;
        exp_win   = 1'b0;
        chk("clr_steps", steps, 0);
        chk("clr_win", win, 0);

        // Saturation: 16 successful walks on a 4-bit counter
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) run_cmd("sat_rt", mk(9), RT, mk(10), 1, 0, 0, 0, 0);
            else            run_cmd("sat_lf", mk(10), LF, mk(9), 1, 0, 0, 0, 0);
        end
        @(negedge clk);
        chk("sat_steps", steps, SMAX);

        // step_clr in the same cycle as the increment
        run_cmd("clr_walk", mk(9), RT, mk(10), 1, 0, 0, 1, 0);
        run_cmd("walk_after_clr", mk(9), RT, mk(10), 1, 0, 0, 0, 0);

        // Reset during COMMIT
        @(negedge clk);
        cur_state = mk(9);
        cmd_dir   = RT;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #2 r_n = 1'b0;
        #1;
        chk("rstc_st_en", st_en, 0);
        chk("rstc_done", move_done, 0);
        chk("rstc_steps", steps, 0);
        chk("rstc_st_d", st_d, 0);
        chk("rstc_win", win, 0);
        @(negedge clk);
        r_n = 1'b1;
        exp_steps = '0;
        exp_win   = 1'b0;
        @(negedge clk);
        chk("rstc_ready", cmd_ready, 1);
        run_cmd("walk_after_rst", mk(9), DN, mk(17), 1, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
